i2c_reg_arbiter: RTL and testbench

Shares one single-port synchronous register file between the i2c_slave register bus and a local host port (FPGA fabric or USB bridge).
- I2C writes are never lost.
- i2c_datai always carries a fresh copy of the register at the slave's current register address, ready before the slave samples it at the ACK.
- Host accesses use a req/ack handshake and are served in the gaps.

---
 rtl/i2c_reg_arbiter_pkg.sv | 16 +
 rtl/i2c_reg_arbiter_if.sv | 52 +++++
 rtl/i2c_reg_arbiter.sv | 154 +++++++++++++++
 tb/tb_i2c_reg_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_arbiter_pkg.sv
// Shared types and defaults for the I2C / host register-file arbiter.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 8;
  localparam int unsigned I2C_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_I2C_WR     = 3'd1,
    S_FETCH      = 3'd2,
    S_FETCH_WAIT = 3'd3,
    S_HOST_ACC   = 3'd4,
    S_HOST_WAIT  = 3'd5
  } arb_state_e;

endpackage

// File: rtl/i2c_reg_arbiter_if.sv
// Bundles the I2C slave register bus, the host port and the register-file port.
interface i2c_reg_arbiter_if
  import i2c_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = I2C_ADDR_W,
  parameter int unsigned DATA_WIDTH = I2C_DATA_W
) ();

  logic                  i2c_we;
  logic [ADDR_WIDTH-1:0] i2c_addr;
  logic [DATA_WIDTH-1:0] i2c_wdata;
  logic                  i2c_busy;
  logic [DATA_WIDTH-1:0] i2c_rdata;

  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ack;
  logic [DATA_WIDTH-1:0] host_rdata;

  logic                  rf_en;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [DATA_WIDTH-1:0] rf_rdata;

  logic                  wr_overflow;

  // Arbiter side
  modport slave (
    input  i2c_we, i2c_addr, i2c_wdata, i2c_busy,
    output i2c_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output rf_en, rf_we, rf_addr, rf_wdata,
    input  rf_rdata,
    output wr_overflow
  );

  // Environment side: slave, host and register file
  modport master (
    output i2c_we, i2c_addr, i2c_wdata, i2c_busy,
    input  i2c_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  rf_en, rf_we, rf_addr, rf_wdata,
    output rf_rdata,
    input  wr_overflow
  );

endinterface

// File: rtl/i2c_reg_arbiter.sv
// Arbitrates one single-port register file between the I2C slave and a host port.
// Register-file strobes are computed one cycle ahead so they are flops in the access cycle.
module i2c_reg_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = I2C_ADDR_W,
  parameter int unsigned DATA_WIDTH   = I2C_DATA_W,
  parameter bit          HOST_LOCKOUT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  i2c_reg_arbiter_if.slave   bus
);

  arb_state_e            state_q, state_d;
  logic                  pend_wr_q, pend_wr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_overflow_q, wr_overflow_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic                  refetch_q, refetch_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] i2c_rdata_q, i2c_rdata_d;
  logic                  rf_en_q, rf_en_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  host_ack_q, host_ack_d;

  logic addr_moved;
  logic wr_hit;
  logic busy_rise;
  logic host_ok;

  // Events that make the cached i2c_rdata stale
  always_comb begin
    addr_moved = (bus.i2c_addr != fetch_addr_q);
    wr_hit     = rf_en_q && rf_we_q && (rf_addr_q == fetch_addr_q);
    busy_rise  = bus.i2c_busy && !busy_q;
    host_ok    = (HOST_LOCKOUT == 1'b0) || !bus.i2c_busy;
  end

  always_comb begin
    state_d       = state_q;
    pend_wr_d     = pend_wr_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_overflow_d = wr_overflow_q;
    fetch_addr_d  = fetch_addr_q;
    refetch_d     = refetch_q || addr_moved || wr_hit || busy_rise;
    busy_d        = bus.i2c_busy;
    i2c_rdata_d   = i2c_rdata_q;
    rf_en_d       = 1'b0;
    rf_we_d       = 1'b0;
    rf_addr_d     = '0;
    rf_wdata_d    = '0;
    host_ack_d    = 1'b0;

    // A pending write retires in the I2C_WR cycle; a strobe then is a fresh write, not a lost one
    if (state_q == S_I2C_WR) pend_wr_d = 1'b0;
    if (bus.i2c_we) begin
      pend_wr_d = 1'b1;
      wr_addr_d = bus.i2c_addr;
      wr_data_d = bus.i2c_wdata;
      if (pend_wr_q && (state_q != S_I2C_WR)) wr_overflow_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pend_wr_q || bus.i2c_we) begin
          state_d    = S_I2C_WR;
          rf_en_d    = 1'b1;
          rf_we_d    = 1'b1;
          rf_addr_d  = wr_addr_d;
          rf_wdata_d = wr_data_d;
        end else if (refetch_q || addr_moved || busy_rise) begin
          state_d      = S_FETCH;
          rf_en_d      = 1'b1;
          rf_addr_d    = bus.i2c_addr;
          fetch_addr_d = bus.i2c_addr;
          refetch_d    = 1'b0;
        end else if (bus.host_req && host_ok) begin
          state_d    = S_HOST_ACC;
          rf_en_d    = 1'b1;
          rf_we_d    = bus.host_we;
          rf_addr_d  = bus.host_addr;
          rf_wdata_d = bus.host_wdata;
          host_ack_d = bus.host_we;
        end
      end
      S_I2C_WR:     state_d = S_IDLE;
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        i2c_rdata_d = bus.rf_rdata;
        state_d     = S_IDLE;
      end
      S_HOST_ACC: begin
        if (rf_we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_HOST_WAIT;
          host_ack_d = 1'b1;
        end
      end
      S_HOST_WAIT:  state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pend_wr_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_overflow_q <= 1'b0;
      fetch_addr_q  <= '0;
      refetch_q     <= 1'b1;
      busy_q        <= 1'b0;
      i2c_rdata_q   <= '0;
      rf_en_q       <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_addr_q     <= '0;
      rf_wdata_q    <= '0;
      host_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_wr_q     <= pend_wr_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_overflow_q <= wr_overflow_d;
      fetch_addr_q  <= fetch_addr_d;
      refetch_q     <= refetch_d;
      busy_q        <= busy_d;
      i2c_rdata_q   <= i2c_rdata_d;
      rf_en_q       <= rf_en_d;
      rf_we_q       <= rf_we_d;
      rf_addr_q     <= rf_addr_d;
      rf_wdata_q    <= rf_wdata_d;
      host_ack_q    <= host_ack_d;
    end
  end

  assign bus.i2c_rdata   = i2c_rdata_q;
  assign bus.host_ack    = host_ack_q;
  // Host read data is the register file's output register, forwarded only in the ack cycle
  assign bus.host_rdata  = (state_q == S_HOST_WAIT) ? bus.rf_rdata : '0;
  assign bus.rf_en       = rf_en_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.wr_overflow = wr_overflow_q;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Randomized self-checking bench for i2c_reg_arbiter against a register-array reference model.
module tb_i2c_reg_arbiter;
  import i2c_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_reg_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  i2c_reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOST_LOCKOUT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] init_val(input logic [7:0] a);
    case (a)
      8'h00:   return 16'hA5A5;
      8'h12:   return 16'h1234;
      8'h40:   return 16'hC0DE;
      default: return {~a, a};
    endcase
  endfunction

  // External register file: reads return data one cycle after the strobe
  logic [15:0] mem [256];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      bus.rf_rdata <= '0;
    end else begin
      if (bus.rf_en && bus.rf_we)  mem[bus.rf_addr] <= bus.rf_wdata;
      if (bus.rf_en && !bus.rf_we) bus.rf_rdata <= mem[bus.rf_addr];
    end
  end

  // Expected register contents, updated from the intent of each transaction
  logic [15:0] ref_mem [256];

  int          ack_cnt  = 0;
  int          spur_cnt = 0;
  int          wr_cnt   = 0;
  logic [23:0] last_wr  = '0;
  always @(posedge clk) begin
    #1;
    if (bus.host_ack) begin
      ack_cnt++;
      if (!bus.host_req) spur_cnt++;
    end
    if (bus.rf_en && bus.rf_we) begin
      wr_cnt++;
      last_wr = {bus.rf_addr, bus.rf_wdata};
    end
  end

  task automatic host_xfer(input logic we, input logic [7:0] a, input logic [15:0] wd,
                           output logic [15:0] rd, output int lat);
    logic found;
    found          = 1'b0;
    rd             = '0;
    lat            = 0;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = wd;
    bus.host_req   = 1'b1;
    while (!found && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.host_ack) begin
        found = 1'b1;
        rd    = bus.host_rdata;
      end
    end
    bus.host_req = 1'b0;
    chk("host_ack_timeout", 32'(found), 32'd1);
    if (found && we) ref_mem[a] = wd;
  endtask

  // Single write strobe from the slave; the rf write must follow within 3 cycles
  task automatic i2c_write(input logic [7:0] a, input logic [15:0] d);
    logic found;
    found         = 1'b0;
    bus.i2c_addr  = a;
    bus.i2c_wdata = d;
    bus.i2c_we    = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) bus.i2c_we = 1'b0;
      if (bus.rf_en && bus.rf_we && bus.rf_addr == a && bus.rf_wdata == d) found = 1'b1;
    end
    chk("i2c_wr_latency", 32'(found), 32'd1);
    ref_mem[a] = d;
  endtask

  task automatic wait_rdata(input string tag, input logic [15:0] exp, input int max);
    int k;
    k = 0;
    while (k < max && bus.i2c_rdata !== exp) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(bus.i2c_rdata), 32'(exp));
  endtask

  logic [15:0] rd, exp_rd, id, hd;
  logic [7:0]  ha, ia;
  logic        found;
  int          lat, a0, w0, hop, off, do_i2c;

  initial begin
    reset          = 1'b1;
    preload        = 1'b1;
    bus.i2c_we     = 1'b0;
    bus.i2c_addr   = 8'h00;
    bus.i2c_wdata  = '0;
    bus.i2c_busy   = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    repeat (3) @(negedge clk);
    preload = 1'b0;

    // Reset values
    chk("rst_i2c_rdata", 32'(bus.i2c_rdata), 32'd0);
    chk("rst_host_ack",  32'(bus.host_ack), 32'd0);
    chk("rst_rf_bus",    32'({bus.rf_en, bus.rf_we, bus.rf_addr, bus.rf_wdata}), 32'd0);
    chk("rst_overflow",  32'(bus.wr_overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_fetch_addr0", 32'({bus.rf_en, bus.rf_we, bus.rf_addr}), 32'({1'b1, 1'b0, 8'h00}));
    wait_rdata("rst_fetch_data", 16'hA5A5, 2);

    // Slave moves to a new register
    repeat (4) @(negedge clk);
    bus.i2c_addr = 8'h12;
    wait_rdata("addr_change", 16'h1234, 6);

    // Host write to the register the slave is looking at
    repeat (4) @(negedge clk);
    host_xfer(1'b1, 8'h12, 16'h5555, rd, lat);
    chk("host_wr_latency", 32'(lat), 32'd1);
    wait_rdata("host_wr_refetch", 16'h5555, 4);

    // I2C write lands while a host read is in flight
    repeat (4) @(negedge clk);
    a0 = ack_cnt;
    fork
      begin
        host_xfer(1'b0, 8'h40, '0, rd, lat);
        chk("host_rd_data", 32'(rd), 32'(ref_mem[8'h40]));
        chk("host_rd_latency", 32'(lat), 32'd2);
      end
      begin
        @(negedge clk);
        i2c_write(8'h10, 16'hBEEF);
      end
    join
    repeat (2) @(negedge clk);
    chk("host_ack_once", 32'(ack_cnt - a0), 32'd1);
    chk("no_overflow", 32'(bus.wr_overflow), 32'd0);

    // Host lockout while the slave is busy
    repeat (6) @(negedge clk);
    a0             = ack_cnt;
    bus.i2c_busy   = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 8'h41;
    bus.host_req   = 1'b1;
    repeat (8) @(negedge clk);
    chk("lockout_no_ack", 32'(ack_cnt - a0), 32'd0);
    bus.i2c_busy = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 3 && !found; k++) begin
      @(negedge clk);
      if (bus.host_ack) begin
        found = 1'b1;
        rd    = bus.host_rdata;
      end
    end
    bus.host_req = 1'b0;
    chk("lockout_release_ack", 32'(found), 32'd1);
    chk("lockout_rd_data", 32'(rd), 32'(ref_mem[8'h41]));

    // Two back-to-back strobes while a host read sits in HOST_WAIT
    repeat (6) @(negedge clk);
    w0 = wr_cnt;
    fork
      host_xfer(1'b0, 8'h42, '0, rd, lat);
      begin
        repeat (2) @(negedge clk);
        bus.i2c_addr  = 8'h20;
        bus.i2c_wdata = 16'h1111;
        bus.i2c_we    = 1'b1;
        @(negedge clk);
        bus.i2c_wdata = 16'h2222;
        @(negedge clk);
        bus.i2c_we    = 1'b0;
      end
    join
    ref_mem[8'h20] = 16'h2222;
    repeat (4) @(negedge clk);
    chk("ovf_write_count", 32'(wr_cnt - w0), 32'd1);
    chk("ovf_last_wins", 32'(last_wr), 32'({8'h20, 16'h2222}));
    chk("ovf_flag", 32'(bus.wr_overflow), 32'd1);
    repeat (5) @(negedge clk);
    chk("ovf_sticky", 32'(bus.wr_overflow), 32'd1);

    // Reset in the middle of a host read aborts it
    a0 = ack_cnt;
    bus.host_we   = 1'b0;
    bus.host_addr = 8'h50;
    bus.host_req  = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_no_ack", 32'(bus.host_ack), 32'd0);
    bus.host_req = 1'b0;
    reset = 1'b0;
    chk("abort_ack_count", 32'(ack_cnt - a0), 32'd0);
    chk("abort_ovf_clear", 32'(bus.wr_overflow), 32'd0);
    wait_rdata("abort_refetch", ref_mem[8'h20], 4);
    host_xfer(1'b0, 8'h50, '0, rd, lat);
    chk("abort_rereq_data", 32'(rd), 32'(ref_mem[8'h50]));

    // Random overlapping host and I2C traffic; host uses 0x40-0x7F, I2C writes 0x00-0x3F
    for (int it = 0; it < 40; it++) begin
      hop    = int'($urandom_range(0, 2));
      ha     = 8'(8'h40 + $urandom_range(0, 63));
      hd     = 16'($urandom);
      do_i2c = int'($urandom_range(0, 1));
      ia     = 8'($urandom_range(0, 63));
      id     = 16'($urandom);
      off    = int'($urandom_range(0, 3));
      exp_rd = ref_mem[ha];
      a0     = ack_cnt;
      fork
        begin
          if (hop != 0) begin
            host_xfer(hop == 2, ha, hd, rd, lat);
            if (hop == 1) chk("rnd_host_rd", 32'(rd), 32'(exp_rd));
          end
        end
        begin
          if (do_i2c != 0) begin
            repeat (off) @(negedge clk);
            i2c_write(ia, id);
          end
        end
      join
      repeat (2) @(negedge clk);
      if (hop != 0) chk("rnd_ack_once", 32'(ack_cnt - a0), 32'd1);
      if ($urandom_range(0, 1) == 1) bus.i2c_addr = 8'($urandom_range(0, 127));
      repeat (6) @(negedge clk);
      chk("rnd_i2c_rdata", 32'(bus.i2c_rdata), 32'(ref_mem[bus.i2c_addr]));
    end

    chk("ack_without_req", 32'(spur_cnt), 32'd0);
    chk("end_no_overflow", 32'(bus.wr_overflow), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
